// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
//   CPU datapath core: an 8 x 8-bit register file feeding a combinational
//   8-bit ALU. The ALU result is the register-file write data.
//
//   ALU operand 1 is read port 1 (REGOUT1). Operand 2 (DATA2) arrives
//   already muxed from outside: register port 2, its negation, or an
//   immediate.
//
// Optional feature (compile-time macro):
//   ALU_ZERO_FLAG_EN - adds output ZERO = (ALURESULT == 0).
//
// Ports:
//   CLK          in   1       clock; register writes on the rising edge
//   RESET        in   1       asynchronous, active-high; clears all registers
//   READREG1     in   ADDR_W  read port 1 address (ALU operand 1)
//   READREG2     in   ADDR_W  read port 2 address
//   WRITEREG     in   ADDR_W  write address for ALURESULT
//   WRITEENABLE  in   1       write ALURESULT to WRITEREG at the next edge
//   ALUOP        in   3       ALU operation select
//   DATA2        in   DATA_W  ALU operand 2
//   REGOUT1      out  DATA_W  contents of register READREG1
//   REGOUT2      out  DATA_W  contents of register READREG2
//   ALURESULT    out  DATA_W  ALU result
//   ZERO         out  1       ALURESULT is zero (ALU_ZERO_FLAG_EN only)
// ---------------------------------------------------------------------------
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] READREG1,
    input  logic [ADDR_W-1:0] READREG2,
    input  logic [ADDR_W-1:0] WRITEREG,
    input  logic              WRITEENABLE,
    input  logic [2:0]        ALUOP,
    input  logic [DATA_W-1:0] DATA2,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    output logic [DATA_W-1:0] ALURESULT
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic              ZERO
`endif
);

    localparam int REG_CNT = 2 ** ADDR_W;

    localparam logic [2:0] OP_FORWARD = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;

    logic [DATA_W-1:0] regs_r [REG_CNT];
    logic [DATA_W-1:0] alu_result_s;

    // Register array: async clear on RESET, which also suppresses any write
    // pending on the same edge; otherwise one write per enabled edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (WRITEENABLE) begin
            regs_r[WRITEREG] <= alu_result_s;
        end
    end

    // Combinational read ports with no write bypass: a read of the register
    // being written returns the old value until the edge.
    always_comb begin
        REGOUT1 = regs_r[READREG1];
        REGOUT2 = regs_r[READREG2];
    end

    // ALU; carry out of ADD is discarded, reserved opcodes yield zero.
    always_comb begin
        alu_result_s = {DATA_W{1'b0}};
        case (ALUOP)
            OP_FORWARD: alu_result_s = DATA2;
            OP_ADD:     alu_result_s = REGOUT1 + DATA2;
            OP_AND:     alu_result_s = REGOUT1 & DATA2;
            OP_OR:      alu_result_s = REGOUT1 | DATA2;
            default:    alu_result_s = {DATA_W{1'b0}};
        endcase
    end

    // Drive the result port from the internal ALU value.
    always_comb begin
        ALURESULT = alu_result_s;
    end

`ifdef ALU_ZERO_FLAG_EN
    // Zero flag; reserved opcodes produce a zero result and so assert it.
    always_comb begin
        ZERO = (alu_result_s == {DATA_W{1'b0}});
    end
`endif

endmodule

// File: tb/tb_alu_regfile.sv
// ---------------------------------------------------------------------------
// tb_alu_regfile
//   Directed self-checking bench for alu_regfile. Each scenario task drives
//   stimulus and compares outputs against hand-computed values. Inputs change
//   1 time unit after the rising edge; outputs are sampled before the next.
// ---------------------------------------------------------------------------
module tb_alu_regfile;

    logic       CLK;
    logic       RESET;
    logic [2:0] READREG1;
    logic [2:0] READREG2;
    logic [2:0] WRITEREG;
    logic       WRITEENABLE;
    logic [2:0] ALUOP;
    logic [7:0] DATA2;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic [7:0] ALURESULT;
`ifdef ALU_ZERO_FLAG_EN
    logic       ZERO;
`endif

    int checks;
    int failures;

    alu_regfile #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .READREG1   (READREG1),
        .READREG2   (READREG2),
        .WRITEREG   (WRITEREG),
        .WRITEENABLE(WRITEENABLE),
        .ALUOP      (ALUOP),
        .DATA2      (DATA2),
        .REGOUT1    (REGOUT1),
        .REGOUT2    (REGOUT2),
        .ALURESULT  (ALURESULT)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .ZERO       (ZERO)
`endif
    );

    // 20-unit clock period.
    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Read a register through port 2 (takes 1 time unit).
    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        READREG2 = a;
        #1;
        d = REGOUT2;
    endtask

    // Single register write via FORWARD.
    task automatic load(input logic [2:0] a, input logic [7:0] v);
        ALUOP = 3'b000;
        DATA2 = v;
        WRITEREG = a;
        WRITEENABLE = 1'b1;
        step();
        WRITEENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        RESET = 1'b1;
        WRITEENABLE = 1'b1;
        WRITEREG = 3'd5;
        ALUOP = 3'b000;
        DATA2 = 8'h5A;
        READREG1 = 3'd0;
        READREG2 = 3'd0;
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            checks++;
            if (d !== 8'h00) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=%h", i, d, 8'h00);
            end
        end
        checks++;
        if (REGOUT1 !== 8'h00) begin
            failures++;
            $display("FAIL reset_regout1 got=%h exp=%h", REGOUT1, 8'h00);
        end
        checks++;
        if (ALURESULT !== 8'h5A) begin
            failures++;
            $display("FAIL reset_aluresult got=%h exp=%h", ALURESULT, 8'h5A);
        end
        WRITEENABLE = 1'b0;
        RESET = 1'b0;
        step();
    endtask

    task automatic test_forward();
        logic [7:0] d;
        ALUOP = 3'b000;
        DATA2 = 8'h05;
        WRITEREG = 3'd4;
        WRITEENABLE = 1'b1;
        #1;
        checks++;
        if (ALURESULT !== 8'h05) begin
            failures++;
            $display("FAIL fwd_result got=%h exp=%h", ALURESULT, 8'h05);
        end
        step();
        DATA2 = 8'h03;
        WRITEREG = 3'd2;
        step();
        WRITEENABLE = 1'b0;
        rd(3'd4, d);
        checks++;
        if (d !== 8'h05) begin
            failures++;
            $display("FAIL fwd_reg4 got=%h exp=%h", d, 8'h05);
        end
        rd(3'd2, d);
        checks++;
        if (d !== 8'h03) begin
            failures++;
            $display("FAIL fwd_reg2 got=%h exp=%h", d, 8'h03);
        end
    endtask

    task automatic test_add();
        logic [7:0] d;
        READREG1 = 3'd4;
        DATA2 = 8'h03;
        ALUOP = 3'b001;
        WRITEREG = 3'd6;
        WRITEENABLE = 1'b1;
        #1;
        checks++;
        if (ALURESULT !== 8'h08) begin
            failures++;
            $display("FAIL add_5p3 got=%h exp=%h", ALURESULT, 8'h08);
        end
        step();
        WRITEENABLE = 1'b0;
        rd(3'd6, d);
        checks++;
        if (d !== 8'h08) begin
            failures++;
            $display("FAIL add_reg6 got=%h exp=%h", d, 8'h08);
        end
        DATA2 = 8'hFD;
        #1;
        checks++;
        if (ALURESULT !== 8'h02) begin
            failures++;
            $display("FAIL add_sub3 got=%h exp=%h", ALURESULT, 8'h02);
        end
        load(3'd7, 8'hFF);
        READREG1 = 3'd7;
        ALUOP = 3'b001;
        DATA2 = 8'h01;
        #1;
        checks++;
        if (ALURESULT !== 8'h00) begin
            failures++;
            $display("FAIL add_wrap got=%h exp=%h", ALURESULT, 8'h00);
        end
`ifdef ALU_ZERO_FLAG_EN
        checks++;
        if (ZERO !== 1'b1) begin
            failures++;
            $display("FAIL add_wrap_zero got=%b exp=%b", ZERO, 1'b1);
        end
`endif
    endtask

    task automatic test_logic();
        load(3'd4, 8'h0C);
        READREG1 = 3'd4;
        READREG2 = 3'd4;
        DATA2 = 8'h0A;
        ALUOP = 3'b010;
        #1;
        checks++;
        if (REGOUT1 !== 8'h0C || REGOUT2 !== 8'h0C) begin
            failures++;
            $display("FAIL same_reg_ports got=%h/%h exp=%h", REGOUT1, REGOUT2, 8'h0C);
        end
        checks++;
        if (ALURESULT !== 8'h08) begin
            failures++;
            $display("FAIL and got=%h exp=%h", ALURESULT, 8'h08);
        end
        ALUOP = 3'b011;
        #1;
        checks++;
        if (ALURESULT !== 8'h0E) begin
            failures++;
            $display("FAIL or got=%h exp=%h", ALURESULT, 8'h0E);
        end
`ifdef ALU_ZERO_FLAG_EN
        checks++;
        if (ZERO !== 1'b0) begin
            failures++;
            $display("FAIL or_zero got=%b exp=%b", ZERO, 1'b0);
        end
`endif
        for (int op = 4; op < 8; op++) begin
            ALUOP = 3'(op);
            #1;
            checks++;
            if (ALURESULT !== 8'h00) begin
                failures++;
                $display("FAIL reserved_op%0d got=%h exp=%h", op, ALURESULT, 8'h00);
            end
`ifdef ALU_ZERO_FLAG_EN
            checks++;
            if (ZERO !== 1'b1) begin
                failures++;
                $display("FAIL reserved_zero%0d got=%b exp=%b", op, ZERO, 1'b1);
            end
`endif
        end
    endtask

    task automatic test_hold();
        logic [7:0] d;
        logic [7:0] exp_regs [8];
        exp_regs = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h0C, 8'h00, 8'h08, 8'hFF};
        WRITEENABLE = 1'b0;
        READREG1 = 3'd4;
        for (int i = 0; i < 3; i++) begin
            ALUOP = 3'(i);
            DATA2 = 8'h11 * 8'(i + 1);
            WRITEREG = 3'(i * 3);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            checks++;
            if (d !== exp_regs[i]) begin
                failures++;
                $display("FAIL hold_reg%0d got=%h exp=%h", i, d, exp_regs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        load(3'd1, 8'h01);
        READREG1 = 3'd1;
        WRITEREG = 3'd1;
        DATA2 = 8'h01;
        ALUOP = 3'b001;
        WRITEENABLE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (REGOUT1 !== 8'(i + 1) || ALURESULT !== 8'(i + 2)) begin
                failures++;
                $display("FAIL fb_pre%0d got=%h/%h exp=%h/%h", i, REGOUT1, ALURESULT,
                         8'(i + 1), 8'(i + 2));
            end
            #6;
            checks++;
            if (REGOUT1 !== 8'(i + 1)) begin
                failures++;
                $display("FAIL fb_mid%0d got=%h exp=%h", i, REGOUT1, 8'(i + 1));
            end
            step();
            checks++;
            if (REGOUT1 !== 8'(i + 2)) begin
                failures++;
                $display("FAIL fb_post%0d got=%h exp=%h", i, REGOUT1, 8'(i + 2));
            end
        end
        WRITEENABLE = 1'b0;
    endtask

    task automatic test_reset_midcycle();
        logic [7:0] d;
        ALUOP = 3'b000;
        DATA2 = 8'hAA;
        WRITEREG = 3'd3;
        WRITEENABLE = 1'b1;
        READREG1 = 3'd1;
        #2;
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            checks++;
            if (d !== 8'h00) begin
                failures++;
                $display("FAIL midrst_reg%0d got=%h exp=%h", i, d, 8'h00);
            end
        end
        step();
        rd(3'd3, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL midrst_blocked_write got=%h exp=%h", d, 8'h00);
        end
        checks++;
        if (ALURESULT !== 8'hAA) begin
            failures++;
            $display("FAIL midrst_aluresult got=%h exp=%h", ALURESULT, 8'hAA);
        end
        WRITEENABLE = 1'b0;
        RESET = 1'b0;
        step();
        rd(3'd3, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL postrst_reg3 got=%h exp=%h", d, 8'h00);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_forward();
        test_add();
        test_logic();
        test_hold();
        test_back_to_back();
        test_reset_midcycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
